md_unit: RTL and testbench

- Multiply/divide unit in the E stage, beside the ALU.
- Takes the same forwarded operand pair as the ALU (rs value as A, rt value as B).
- Executes mult/multu/div/divu over a fixed number of cycles and holds the results in architectural HI/LO registers.
- HI/LO feed the E-stage result mux for mfhi/mflo. busy drives the hazard unit, which stalls D whenever an md-class instruction meets start|busy.

---
 rtl/md_unit_if.sv | 16 +
 rtl/md_unit.sv | 113 +++++++++++
 tb/tb_md_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage <-> multiply/divide unit bus.
//   start/md_op/flush/A/B : issue side, driven by the E stage (master)
//   busy/hi/lo            : unit status and architectural HI/LO (slave drives)
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic        flush;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, md_op, flush, A, B, input busy, hi, lo);
    modport slave  (input start, md_op, flush, A, B, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with architectural HI/LO.
//   clk, reset : clock, synchronous active-high reset
//   bus        : md_unit_if.slave
//                start/md_op/flush/A/B in; busy/hi/lo out (all registered)
// The result is computed in the issue cycle and parked in pending_hi/lo;
// busy then models the multi-cycle latency and commits at the last cycle.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] N_MULT = 4'(MULT_CYCLES);
    localparam logic [3:0] N_DIV  = 4'(DIV_CYCLES);

    logic        busy_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] pend_hi_q, pend_lo_q;
    logic        pend_wr_q;   // cleared for divide-by-zero: commit leaves HI/LO alone

    logic        accept;
    logic [63:0] prod_s, prod_u;
    logic        div_s;
    logic [31:0] a_mag, b_mag, dd, ds, uq, ur, quo, rem;

    assign accept = bus.start & ~bus.flush & ~busy_q;

    // Low 64 bits of the product of the sign-extended operands is the
    // signed 32x32 product.
    assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // Signed division done on magnitudes so the 0x80000000 / -1 case and
    // truncation toward zero fall out without relying on signed '/' semantics.
    always_comb begin
        div_s = (bus.md_op == OP_DIV);
        a_mag = bus.A[31] ? (32'd0 - bus.A) : bus.A;
        b_mag = bus.B[31] ? (32'd0 - bus.B) : bus.B;
        dd    = div_s ? a_mag : bus.A;
        ds    = div_s ? b_mag : bus.B;
        if (ds == 32'd0)
            ds = 32'd1;   // keeps the divider X-free; result is discarded
        uq    = dd / ds;
        ur    = dd % ds;
        quo   = (div_s && (bus.A[31] ^ bus.B[31])) ? (32'd0 - uq) : uq;
        rem   = (div_s && bus.A[31]) ? (32'd0 - ur) : ur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= 1'b0;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else if (busy_q) begin
            // New starts are ignored while busy; flush never cancels this.
            if (cnt_q == 4'd1) begin
                if (pend_wr_q) begin
                    hi_q <= pend_hi_q;
                    lo_q <= pend_lo_q;
                end
                busy_q <= 1'b0;
                cnt_q  <= 4'd0;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end else if (accept) begin
            case (bus.md_op)
                OP_MULT: begin
                    pend_hi_q <= prod_s[63:32];
                    pend_lo_q <= prod_s[31:0];
                    pend_wr_q <= 1'b1;
                    cnt_q     <= N_MULT;
                    busy_q    <= 1'b1;
                end
                OP_MULTU: begin
                    pend_hi_q <= prod_u[63:32];
                    pend_lo_q <= prod_u[31:0];
                    pend_wr_q <= 1'b1;
                    cnt_q     <= N_MULT;
                    busy_q    <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    pend_hi_q <= rem;
                    pend_lo_q <= quo;
                    pend_wr_q <= (bus.B != 32'd0);
                    cnt_q     <= N_DIV;
                    busy_q    <= 1'b1;
                end
                OP_MTHI: hi_q <= bus.A;
                OP_MTLO: lo_q <= bus.A;
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed + small random bench for md_unit. Expected HI/LO for
// each mult/div are pushed to a scoreboard at issue and popped at commit.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    md_unit_if bus();

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Independent reference using 64-bit longint arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                          input logic [31:0] oh, ol);
        longint sa, sbv, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sbv); return p; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; return p; end
            3'd3: begin
                if (b == 32'd0) return {oh, ol};
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {oh, ol};
                return {a % b, a / b};
            end
            default: return {oh, ol};
        endcase
    endfunction

    // Issue one mult/div, check busy for n cycles with HI/LO held, then commit.
    // inj: at busy cycle 3 drive a mult, at cycle 4 an mthi; both must be ignored.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, b,
                          input logic [31:0] eh, el, input int n, input bit inj,
                          input string tag);
        logic [31:0] oh, ol;
        logic [63:0] got;
        oh = exp_hi;
        ol = exp_lo;
        sb.push_back({eh, el});
        bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = b;
        cyc();
        bus.start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            chk({tag, " busy"}, 32'(bus.busy), 32'd1);
            chk({tag, " hi hold"}, bus.hi, oh);
            chk({tag, " lo hold"}, bus.lo, ol);
            if (inj && k == 3) begin
                bus.start = 1'b1; bus.md_op = 3'd1; bus.A = 32'd2; bus.B = 32'd3;
            end else if (inj && k == 4) begin
                bus.start = 1'b1; bus.md_op = 3'd5; bus.A = 32'hDEADBEEF;
            end else begin
                bus.start = 1'b0;
            end
            cyc();
        end
        bus.start = 1'b0;
        chk({tag, " busy end"}, 32'(bus.busy), 32'd0);
        if (sb.size() == 0) begin
            tests++; fails++;
            $error("FAIL %s: scoreboard empty, got %0d entries, want 1", tag, sb.size());
        end else begin
            got = sb.pop_front();
            chk({tag, " hi"}, bus.hi, got[63:32]);
            chk({tag, " lo"}, bus.lo, got[31:0]);
        end
        exp_hi = eh;
        exp_lo = el;
    endtask

    task automatic issue1(input logic [2:0] op, input logic [31:0] a, input logic fl);
        bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = 32'd7; bus.flush = fl;
        cyc();
        bus.start = 1'b0; bus.flush = 1'b0;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] m;
        bus.start = 1'b0; bus.md_op = 3'd0; bus.flush = 1'b0;
        bus.A = 32'd0; bus.B = 32'd0;
        cyc(); cyc();
        reset = 1'b0;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);

        run_md(3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, MC, 1'b0, "mult -3*5");
        run_md(3'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, MC, 1'b0, "multu");
        run_md(3'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, MC, 1'b0, "mult -1*2");
        run_md(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC, 1'b0, "div -7/2");
        run_md(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, DC, 1'b0, "divu 7/2");
        run_md(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, DC, 1'b0, "div ovf");

        issue1(3'd5, 32'h12345678, 1'b0);
        chk("mthi busy", 32'(bus.busy), 32'd0);
        chk("mthi hi", bus.hi, 32'h12345678);
        chk("mthi lo", bus.lo, exp_lo);
        exp_hi = 32'h12345678;
        issue1(3'd6, 32'h9ABCDEF0, 1'b0);
        chk("mtlo busy", 32'(bus.busy), 32'd0);
        chk("mtlo hi", bus.hi, 32'h12345678);
        chk("mtlo lo", bus.lo, 32'h9ABCDEF0);
        exp_lo = 32'h9ABCDEF0;
        issue1(3'd0, 32'h11111111, 1'b0);
        issue1(3'd7, 32'h22222222, 1'b0);
        chk("nop busy", 32'(bus.busy), 32'd0);
        chk("nop hi", bus.hi, exp_hi);
        chk("nop lo", bus.lo, exp_lo);

        run_md(3'd4, 32'd5, 32'd0, exp_hi, exp_lo, DC, 1'b0, "divu by 0");

        run_md(3'd3, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, DC, 1'b1, "div ignore");

        // Flush suppresses the same-cycle start.
        bus.start = 1'b1; bus.md_op = 3'd1; bus.A = 32'd9; bus.B = 32'd9; bus.flush = 1'b1;
        cyc();
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush busy", 32'(bus.busy), 32'd0);
        cyc();
        chk("flush busy2", 32'(bus.busy), 32'd0);
        chk("flush hi", bus.hi, exp_hi);
        chk("flush lo", bus.lo, exp_lo);
        issue1(3'd5, 32'h55AA55AA, 1'b1);
        chk("flush mthi", bus.hi, exp_hi);

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(4, 1));
            ra  = $urandom;
            rb  = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
            m   = model(rop, ra, rb, exp_hi, exp_lo);
            run_md(rop, ra, rb, m[63:32], m[31:0], (rop <= 3'd2) ? MC : DC, 1'b0,
                   $sformatf("rand%0d op%0d", i, rop));
        end

        // Reset at busy cycle 4 discards the in-flight mult.
        bus.start = 1'b1; bus.md_op = 3'd1; bus.A = 32'd6; bus.B = 32'd7;
        cyc();
        bus.start = 1'b0;
        cyc(); cyc(); cyc();
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst mid busy", 32'(bus.busy), 32'd0);
        chk("rst mid hi", bus.hi, 32'd0);
        chk("rst mid lo", bus.lo, 32'd0);
        for (int k = 0; k < MC + 3; k++) cyc();
        chk("rst no commit busy", 32'(bus.busy), 32'd0);
        chk("rst no commit hi", bus.hi, 32'd0);
        chk("rst no commit lo", bus.lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
